// File: rtl/multi_pulse_generator_pkg.sv
// Shared types and constants for the multi-channel PPS pulse generator.
package pulse_gen_pkg;

    localparam int TIME_W    = 56;
    localparam int SEC_LSB   = 0;
    localparam int MIN_LSB   = 8;
    localparam int HOUR_LSB  = 16;
    localparam int DAY_LSB   = 24;
    localparam int MONTH_LSB = 32;
    localparam int YEAR_LSB  = 40;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TIME = 3'd1,
        ARMED     = 3'd2,
        OFFSET    = 3'd3,
        RUN       = 3'd4,
        DONE      = 3'd5
    } ch_state_e;

    // Builds a time-of-day word in the Thunderbolt packing {year,month,day,hour,min,sec}.
    function automatic logic [TIME_W-1:0] pack_time(
        input logic [15:0] year,
        input logic [7:0]  month,
        input logic [7:0]  day,
        input logic [7:0]  hour,
        input logic [7:0]  minute,
        input logic [7:0]  sec
    );
        logic [TIME_W-1:0] t;
        t = '0;
        t[YEAR_LSB  +: 16] = year;
        t[MONTH_LSB +: 8]  = month;
        t[DAY_LSB   +: 8]  = day;
        t[HOUR_LSB  +: 8]  = hour;
        t[MIN_LSB   +: 8]  = minute;
        t[SEC_LSB   +: 8]  = sec;
        return t;
    endfunction

endpackage

// File: rtl/multi_pulse_generator_if.sv
// Configuration, time-of-day and pulse-output bundle of multi_pulse_generator.
// PULSE_GEN_POLARITY_EN adds the per-channel i_invert control.
interface multi_pulse_generator_if
    import pulse_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEF
);
    logic                           i_pps_raw;
    logic [NUM_CH-1:0]              i_ch_enable;
    logic [NUM_CH-1:0][TIME_W-1:0]  i_usr_time;
    logic [NUM_CH-1:0][CNT_W-1:0]   i_offset_us;
    logic [NUM_CH-1:0][CNT_W-1:0]   i_width_high;
    logic [NUM_CH-1:0][CNT_W-1:0]   i_width_period;
    logic [NUM_CH-1:0][CNT_W-1:0]   i_pulse_count;
    logic                           i_thunder_packet_dv;
    logic [TIME_W-1:0]              i_thunder_time;
`ifdef PULSE_GEN_POLARITY_EN
    logic [NUM_CH-1:0]              i_invert;
`endif
    logic [NUM_CH-1:0]              o_pulse_out;
    logic [NUM_CH-1:0]              o_ch_armed;
    logic [NUM_CH-1:0]              o_ch_done;

    modport master (
        output i_pps_raw, i_ch_enable, i_usr_time, i_offset_us, i_width_high,
               i_width_period, i_pulse_count, i_thunder_packet_dv, i_thunder_time,
`ifdef PULSE_GEN_POLARITY_EN
               i_invert,
`endif
        input  o_pulse_out, o_ch_armed, o_ch_done
    );

    modport slave (
        input  i_pps_raw, i_ch_enable, i_usr_time, i_offset_us, i_width_high,
               i_width_period, i_pulse_count, i_thunder_packet_dv, i_thunder_time,
`ifdef PULSE_GEN_POLARITY_EN
               i_invert,
`endif
        output o_pulse_out, o_ch_armed, o_ch_done
    );

endinterface

// File: rtl/multi_pulse_generator_pps_us_timebase.sv
// PPS synchroniser/edge detect and the shared microsecond tick counter.
module pps_us_timebase #(
    parameter int CLKS_PER_1_US = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pps_raw,
    output logic pps_rise,
    output logic us_tick
);
    localparam int CLK_W = (CLKS_PER_1_US > 1) ? $clog2(CLKS_PER_1_US) : 1;
    localparam logic [CLK_W-1:0] LAST = CLK_W'(CLKS_PER_1_US - 1);

    logic [1:0]       sync;
    logic [CLK_W-1:0] clk_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync    <= '0;
            clk_cnt <= '0;
        end else begin
            sync <= {sync[0], i_pps_raw};
            if (pps_rise || clk_cnt == LAST) clk_cnt <= '0;
            else                             clk_cnt <= clk_cnt + CLK_W'(1);
        end
    end

    assign pps_rise = (sync == 2'b01);
    // A PPS edge restarts the grid, so the tick that would have landed here is dropped.
    assign us_tick  = (clk_cnt == LAST) && !pps_rise;

endmodule

// File: rtl/multi_pulse_generator.sv
// NUM_CH phase-coherent pulse channels armed by time-of-day match and started on PPS.
// PULSE_GEN_POLARITY_EN adds per-channel output inversion while running.
module multi_pulse_generator
    import pulse_gen_pkg::*;
#(
    parameter int CLKS_PER_1_US = 10,
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    multi_pulse_generator_if.slave bus
);
    logic              pps_rise, us_tick;
    logic [NUM_CH-1:0] pulse_v, armed_v, done_v;

    pps_us_timebase #(.CLKS_PER_1_US(CLKS_PER_1_US)) u_timebase (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_pps_raw (bus.i_pps_raw),
        .pps_rise  (pps_rise),
        .us_tick   (us_tick)
    );

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        ch_state_e        state_q, state_d;
        logic [CNT_W-1:0] width_sh, period_sh, offset_sh, count_sh;
        logic [CNT_W-1:0] us_cnt, off_cnt, pulse_cnt;
        logic [CNT_W-1:0] per_eff, pulse_nxt;
        logic             en, time_hit, wrap, off_done, count_hit;
        logic             pulse_d, pulse_q, armed, done, in_width;
`ifdef PULSE_GEN_POLARITY_EN
        logic             inv_sh;
`endif

        assign en        = bus.i_ch_enable[n];
        assign time_hit  = bus.i_thunder_packet_dv && (bus.i_thunder_time == bus.i_usr_time[n]);
        assign per_eff   = (period_sh == '0) ? CNT_W'(1) : period_sh;
        assign wrap      = us_tick && (us_cnt >= per_eff - CNT_W'(1));
        assign off_done  = us_tick && (off_cnt >= offset_sh - CNT_W'(1));
        assign pulse_nxt = (&pulse_cnt) ? pulse_cnt : pulse_cnt + CNT_W'(1);
        assign count_hit = (count_sh != '0) && (pulse_nxt >= count_sh);
        assign in_width  = (us_cnt < width_sh);

        always_ff @(posedge i_clk) begin : state_reg
            if (i_rst) state_q <= IDLE;
            else       state_q <= state_d;
        end

        always_comb begin : next_state
            state_d = state_q;
            if (!en) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE:      state_d = WAIT_TIME;
                    WAIT_TIME: if (time_hit) state_d = ARMED;
                    ARMED:     if (pps_rise) state_d = (bus.i_offset_us[n] == '0) ? RUN : OFFSET;
                    OFFSET:    if (off_done) state_d = RUN;
                    RUN:       if (wrap && count_hit) state_d = DONE;
                    DONE:      state_d = DONE;
                    default:   state_d = IDLE;
                endcase
            end
        end

        always_comb begin : outputs
            pulse_d = 1'b0;
            armed   = 1'b0;
            done    = 1'b0;
            case (state_q)
                ARMED: armed = 1'b1;
`ifdef PULSE_GEN_POLARITY_EN
                RUN:   pulse_d = in_width ^ inv_sh;
`else
                RUN:   pulse_d = in_width;
`endif
                DONE:  done = 1'b1;
                default: ;
            endcase
        end

        // Shadow config is captured only at the PPS that starts a run.
        always_ff @(posedge i_clk) begin : datapath
            if (i_rst) begin
                pulse_q   <= 1'b0;
                width_sh  <= '0;
                period_sh <= '0;
                offset_sh <= '0;
                count_sh  <= '0;
                us_cnt    <= '0;
                off_cnt   <= '0;
                pulse_cnt <= '0;
`ifdef PULSE_GEN_POLARITY_EN
                inv_sh    <= 1'b0;
`endif
            end else begin
                pulse_q <= pulse_d;
                case (state_q)
                    ARMED: if (pps_rise) begin
                        width_sh  <= bus.i_width_high[n];
                        period_sh <= bus.i_width_period[n];
                        offset_sh <= bus.i_offset_us[n];
                        count_sh  <= bus.i_pulse_count[n];
`ifdef PULSE_GEN_POLARITY_EN
                        inv_sh    <= bus.i_invert[n];
`endif
                        us_cnt    <= '0;
                        off_cnt   <= '0;
                        pulse_cnt <= '0;
                    end
                    OFFSET: if (us_tick) off_cnt <= off_cnt + CNT_W'(1);
                    RUN: begin
                        if (wrap) begin
                            us_cnt    <= '0;
                            pulse_cnt <= pulse_nxt;
                        end else if (us_tick) begin
                            us_cnt <= us_cnt + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign pulse_v[n] = pulse_q;
        assign armed_v[n] = armed;
        assign done_v[n]  = done;
    end

    assign bus.o_pulse_out = pulse_v;
    assign bus.o_ch_armed  = armed_v;
    assign bus.o_ch_done   = done_v;

endmodule
